// File: rtl/tone_synth.sv
// Square-wave tone generator with an attack/sustain/release envelope, writing
// identical signed samples to both audio channels through a one-in-two-cycle strobe.
module tone_synth #(
  parameter int unsigned CNT_W        = 19,
  parameter logic [31:0] AMP_MAX      = 32'd10000000,
  parameter logic [31:0] ATTACK_STEP  = 32'd500000,
  parameter logic [31:0] RELEASE_STEP = 32'd250000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [CNT_W-1:0] half_period,
  input  logic             audio_out_allowed,
  output logic             write_audio_out,
  output logic [31:0]      left_channel_audio_out,
  output logic [31:0]      right_channel_audio_out,
  output logic             note_active,
  output logic [31:0]      amp_level
);

  // Handshake: write_audio_out is a single-cycle strobe raised only when
  // audio_out_allowed was high and no strobe was high the cycle before;
  // sample data is loaded on the raising edge and held stable through it.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             ph_q, ph_d;
  logic [31:0]      amp_q, amp_d;
  logic             wr_q, wr_d;
  logic [31:0]      sample_q, sample_d;
  logic             active_q, active_d;

  logic        note_on;
  logic        half_done;
  logic [32:0] att_sum;
  logic [31:0] att_next;
  logic [31:0] rel_next;

  assign note_on   = (half_period != '0);
  assign half_done = (cnt_q == (per_q - CNT_ONE));
  assign att_sum   = {1'b0, amp_q} + {1'b0, ATTACK_STEP};
  assign att_next  = (att_sum >= {1'b0, AMP_MAX}) ? AMP_MAX : att_sum[31:0];
  assign rel_next  = (amp_q > RELEASE_STEP) ? (amp_q - RELEASE_STEP) : '0;

  // A new pitch is only adopted at a half-period boundary, so no half is cut short.
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    per_d = per_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      ph_d  = 1'b0;
      per_d = half_period;
    end else if (half_done) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
      if (note_on) per_d = half_period;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    case (state_q)
      S_IDLE: begin
        if (note_on) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (!note_on) begin
          state_d = S_RELEASE;
        end else if (wr_q) begin
          amp_d = att_next;
          if (att_next == AMP_MAX) state_d = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        if (!note_on) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (wr_q) amp_d = rel_next;
        // A retrigger wins over reaching zero on the same edge.
        if (note_on) state_d = S_ATTACK;
        else if (wr_q && (rel_next == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d     = audio_out_allowed & ~wr_q;
    sample_d = sample_q;
    if (wr_d) begin
      if (state_q == S_IDLE) sample_d = '0;
      else                   sample_d = ph_q ? amp_q : (~amp_q + 32'd1);
    end
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      ph_q     <= 1'b0;
      amp_q    <= '0;
      wr_q     <= 1'b0;
      sample_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      ph_q     <= ph_d;
      amp_q    <= amp_d;
      wr_q     <= wr_d;
      sample_q <= sample_d;
      active_q <= active_d;
    end
  end

  assign write_audio_out         = wr_q;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign note_active             = active_q;
  assign amp_level               = amp_q;

endmodule
